// File: rtl/penalty_match_ctl.sv
// penalty_match_ctl: solo/versus penalty shootout sequencer with aim timeout, scoring and early finish.
// Optional macro SUDDEN_DEATH_EN: a versus tie after regulation continues with extra rounds.
module penalty_match_ctl #(
  parameter int ROUNDS         = 5,
  parameter int TIMEOUT_FRAMES = 180,
  parameter int SAVE_RADIUS    = 64,
  parameter int COORD_W        = 12,
  parameter int SCORE_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               solo_enable,
  input  logic               left_clicked,
  input  logic               vsync,
  input  logic               ball_valid,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] glove_x,
  output logic [2:0]         state,
  output logic               shooter,
  output logic [7:0]         round,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               goal_pulse,
  output logic               save_pulse,
  output logic [1:0]         winner
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_FLIGHT = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int                 TW         = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TW-1:0]      LP_TO_LAST = TW'(TIMEOUT_FRAMES - 1);
  localparam logic [COORD_W:0]   LP_RADIUS  = (COORD_W + 1)'(SAVE_RADIUS);
  localparam logic [SCORE_W-1:0] LP_SMAX    = '1;
  localparam logic [7:0]         LP_ROUNDS8 = 8'(ROUNDS);
  localparam logic [15:0]        LP_ROUNDS  = 16'(ROUNDS);

  state_t             r_state;
  logic               r_clk_sync, r_clk_prev, r_vs_sync, r_vs_prev;
  logic               r_solo, r_shooter, r_goal, r_save;
  logic [7:0]         r_round;
  logic [SCORE_W-1:0] r_score_a, r_score_b;
  logic [1:0]         r_winner;
  logic [TW-1:0]      r_frames;

  logic                      w_click, w_tick, w_save, w_neq, w_early, w_solo_over, w_vs_over;
  logic signed [COORD_W:0]   w_diff;
  logic        [COORD_W:0]   w_dist;
  logic [SCORE_W-1:0]        w_sa_inc, w_sb_inc;
  logic [15:0]               w_a16, w_b16, w_rem_a, w_rem_b;
  logic [1:0]                w_winner;

  assign w_click = r_clk_sync & ~r_clk_prev;
  assign w_tick  = r_vs_sync & ~r_vs_prev;

  assign w_diff = $signed({1'b0, ball_x}) - $signed({1'b0, glove_x});
  assign w_dist = w_diff[COORD_W] ? (~w_diff + 1'b1) : w_diff;
  assign w_save = (w_dist <= LP_RADIUS);

  assign w_sa_inc = (r_score_a == LP_SMAX) ? r_score_a : r_score_a + 1'b1;
  assign w_sb_inc = (r_score_b == LP_SMAX) ? r_score_b : r_score_b + 1'b1;

  // Shots left include the current round; B still owes one when A has just shot.
  assign w_a16   = 16'(r_score_a);
  assign w_b16   = 16'(r_score_b);
  assign w_rem_a = LP_ROUNDS - 16'(r_round);
  assign w_rem_b = w_rem_a + {15'd0, ~r_shooter};
  assign w_neq   = (r_score_a != r_score_b);
  assign w_early = (r_round <= LP_ROUNDS8) &
                   ((w_a16 > w_b16 + w_rem_b) | (w_b16 > w_a16 + w_rem_a));

  assign w_solo_over = (r_round >= LP_ROUNDS8);
`ifdef SUDDEN_DEATH_EN
  assign w_vs_over = w_early | (r_shooter & (r_round >= LP_ROUNDS8) & w_neq);
`else
  assign w_vs_over = w_early | (r_shooter & (r_round == LP_ROUNDS8));
`endif

  assign w_winner = (r_score_a > r_score_b) ? 2'b01 :
                    (r_score_a < r_score_b) ? 2'b10 : 2'b11;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_sync <= 1'b0;
      r_clk_prev <= 1'b0;
      r_vs_sync  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_solo     <= 1'b0;
      r_shooter  <= 1'b0;
      r_round    <= 8'd0;
      r_score_a  <= '0;
      r_score_b  <= '0;
      r_goal     <= 1'b0;
      r_save     <= 1'b0;
      r_winner   <= 2'b00;
      r_frames   <= '0;
    end else begin
      r_clk_sync <= left_clicked;
      r_clk_prev <= r_clk_sync;
      r_vs_sync  <= vsync;
      r_vs_prev  <= r_vs_sync;
      r_goal     <= 1'b0;
      r_save     <= 1'b0;
      case (r_state)
        S_IDLE: if (w_click) begin
          r_solo    <= solo_enable;
          r_score_a <= '0;
          r_score_b <= '0;
          r_frames  <= '0;
          r_round   <= 8'd1;
          r_shooter <= 1'b0;
          r_winner  <= 2'b00;
          r_state   <= S_AIM;
        end
        // A click landing on the expiring tick still counts as a shot.
        S_AIM: if (w_click) begin
          r_state <= S_FLIGHT;
        end else if (w_tick) begin
          if (r_frames == LP_TO_LAST) begin
            r_save  <= 1'b1;
            if (r_solo) r_score_b <= w_sb_inc;
            r_state <= S_RESULT;
          end else begin
            r_frames <= r_frames + 1'b1;
          end
        end
        S_FLIGHT: if (ball_valid) begin
          if (w_save) begin
            r_save <= 1'b1;
            if (r_solo) r_score_b <= w_sb_inc;
          end else begin
            r_goal <= 1'b1;
            if (r_shooter) r_score_b <= w_sb_inc;
            else           r_score_a <= w_sa_inc;
          end
          r_state <= S_RESULT;
        end
        S_RESULT: if (w_tick) begin
          r_frames <= '0;
          if (r_solo ? w_solo_over : w_vs_over) begin
            r_winner <= w_winner;
            r_state  <= S_OVER;
          end else begin
            r_state <= S_AIM;
            if (r_solo || r_shooter)
              r_round <= (r_round == 8'hFF) ? r_round : r_round + 8'd1;
            if (!r_solo) r_shooter <= ~r_shooter;
          end
        end
        S_OVER: if (w_click) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state      = r_state;
  assign shooter    = r_shooter;
  assign round      = r_round;
  assign score_a    = r_score_a;
  assign score_b    = r_score_b;
  assign goal_pulse = r_goal;
  assign save_pulse = r_save;
  assign winner     = r_winner;
endmodule

// File: tb/tb_penalty_match_ctl.sv
// Bench for penalty_match_ctl: match-level reference model compared every cycle,
// directed shootout scenarios with literal expectations, then a randomized input stream.
module tb_penalty_match_ctl;
  localparam int ROUNDS  = 5;
  localparam int TIMEOUT = 180;
  localparam int RADIUS  = 64;
  localparam int SMAX    = 15;
  localparam int P_IDLE = 0, P_AIM = 1, P_FLIGHT = 2, P_RESULT = 3, P_OVER = 4;

  logic        clk = 1'b0;
  logic        rst, solo_in, lc, vs, bv;
  logic [11:0] bx, gx;
  logic [2:0]  d_state;
  logic        d_shooter, d_goal, d_save;
  logic [7:0]  d_round;
  logic [3:0]  d_sa, d_sb;
  logic [1:0]  d_winner;

  penalty_match_ctl #(.ROUNDS(ROUNDS), .TIMEOUT_FRAMES(TIMEOUT), .SAVE_RADIUS(RADIUS),
                      .COORD_W(12), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .solo_enable(solo_in), .left_clicked(lc), .vsync(vs),
    .ball_valid(bv), .ball_x(bx), .glove_x(gx), .state(d_state), .shooter(d_shooter),
    .round(d_round), .score_a(d_sa), .score_b(d_sb), .goal_pulse(d_goal),
    .save_pulse(d_save), .winner(d_winner));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;
  int n_goal = 0, n_save = 0;
  int last_goal, last_save;

  // Reference model: match progress kept as shots taken per player.
  int m_phase, m_shooter, m_round, m_sa, m_sb, m_goal, m_save, m_win;
  int m_solo, m_shots_a, m_shots_b, m_frames;
  bit m_lc1, m_lc2, m_vs1, m_vs2;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_shooter = 0; m_round = 0; m_sa = 0; m_sb = 0;
    m_goal = 0; m_save = 0; m_win = 0; m_solo = 0; m_shots_a = 0; m_shots_b = 0;
    m_frames = 0; m_lc1 = 0; m_lc2 = 0; m_vs1 = 0; m_vs2 = 0;
  endtask

  task automatic resolve(input bit goal);
    if (goal) begin
      m_goal = 1;
      if (m_shooter != 0) m_sb = sat(m_sb + 1);
      else                m_sa = sat(m_sa + 1);
    end else begin
      m_save = 1;
      if (m_solo != 0) m_sb = sat(m_sb + 1);
    end
    m_phase = P_RESULT;
  endtask

  task automatic advance();
    bit over, in_reg, early, pair;
    if (m_shooter != 0) m_shots_b++; else m_shots_a++;
    if (m_solo != 0) begin
      over = (m_shots_a >= ROUNDS);
    end else begin
      in_reg = (m_shots_a <= ROUNDS) && (m_shots_b <= ROUNDS);
      early  = in_reg && ((m_sa > m_sb + ROUNDS - m_shots_b) || (m_sb > m_sa + ROUNDS - m_shots_a));
      pair   = (m_shots_a == m_shots_b) && (m_shots_b >= ROUNDS);
`ifdef SUDDEN_DEATH_EN
      over = early || (pair && (m_sa != m_sb));
`else
      over = early || pair;
`endif
    end
    if (over) begin
      m_phase = P_OVER;
      m_win = (m_sa > m_sb) ? 1 : (m_sa < m_sb) ? 2 : 3;
    end else begin
      m_phase   = P_AIM;
      m_frames  = 0;
      m_shooter = (m_solo == 0 && m_shots_a > m_shots_b) ? 1 : 0;
      m_round   = ((m_solo != 0) ? m_shots_a : m_shots_b) + 1;
      if (m_round > 255) m_round = 255;
    end
  endtask

  task automatic model_step();
    bit click, tick;
    int d;
    click = m_lc1 && !m_lc2;
    tick  = m_vs1 && !m_vs2;
    m_lc2 = m_lc1; m_lc1 = lc; m_vs2 = m_vs1; m_vs1 = vs;
    m_goal = 0; m_save = 0;
    case (m_phase)
      P_IDLE: if (click) begin
        m_solo = solo_in ? 1 : 0; m_sa = 0; m_sb = 0; m_shots_a = 0; m_shots_b = 0;
        m_round = 1; m_shooter = 0; m_win = 0; m_frames = 0; m_phase = P_AIM;
      end
      P_AIM: if (click) m_phase = P_FLIGHT;
             else if (tick) begin
               m_frames++;
               if (m_frames >= TIMEOUT) resolve(0);
             end
      P_FLIGHT: if (bv) begin
        d = int'(bx) - int'(gx);
        if (d < 0) d = -d;
        resolve(d > RADIUS);
      end
      P_RESULT: if (tick) advance();
      P_OVER: if (click) m_phase = P_IDLE;
      default: ;
    endcase
  endtask

  task automatic cyc();
    if (rst) model_reset();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",   int'(d_state),   m_phase);
      check("shooter", int'(d_shooter), m_shooter);
      check("round",   int'(d_round),   m_round);
      check("score_a", int'(d_sa),      m_sa);
      check("score_b", int'(d_sb),      m_sb);
      check("goal",    int'(d_goal),    m_goal);
      check("save",    int'(d_save),    m_save);
      check("winner",  int'(d_winner),  m_win);
      if (d_goal) n_goal++;
      if (d_save) n_save++;
    end
  end

  task automatic click();
    lc = 1; cyc(); lc = 0; cyc(); cyc();
  endtask

  task automatic tick();
    vs = 1; cyc(); vs = 0; cyc();
    last_goal = d_goal; last_save = d_save;
    cyc();
  endtask

  task automatic ball(input int x, input int g);
    bv = 1; bx = 12'(x); gx = 12'(g); cyc();
    last_goal = d_goal; last_save = d_save;
    bv = 0; cyc();
  endtask

  task automatic shot(input int x, input int g);
    click(); ball(x, g); tick();
  endtask

  task automatic start(input bit solo);
    solo_in = solo; click();
  endtask

  initial begin
    int x, g;
    rst = 1; solo_in = 0; lc = 0; vs = 0; bv = 0; bx = '0; gx = '0;
    model_reset();
    cyc();
    chk_en = 1;
    cyc();
    check("rst_state", int'(d_state), 0);
    check("rst_round", int'(d_round), 0);
    check("rst_winner", int'(d_winner), 0);
    rst = 0;
    cyc();

    // Solo, every shot scores.
    n_goal = 0;
    start(1);
    repeat (ROUNDS) shot(600, 100);
    check("solo_sa", int'(d_sa), 5);
    check("solo_sb", int'(d_sb), 0);
    check("solo_state", int'(d_state), P_OVER);
    check("solo_winner", int'(d_winner), 1);
    check("solo_goals", n_goal, 5);
    click();
    check("over_to_idle", int'(d_state), P_IDLE);

    // Save radius boundary.
    start(1);
    click(); ball(164, 100);
    check("dist64_save", last_save, 1);
    check("dist64_goal", last_goal, 0);
    tick();
    click(); ball(165, 100);
    check("dist65_goal", last_goal, 1);
    tick();
    repeat (3) shot(100, 130);
    check("bnd_sb", int'(d_sb), 4);
    check("bnd_winner", int'(d_winner), 2);
    click();

    // Aim timeout, then a click coinciding with the expiring tick.
    start(1);
    n_save = 0;
    repeat (TIMEOUT - 1) tick();
    check("to_early", n_save, 0);
    tick();
    check("to_save", last_save, 1);
    check("to_sb", int'(d_sb), 1);
    check("to_state", int'(d_state), P_RESULT);
    tick();
    repeat (TIMEOUT - 1) tick();
    lc = 1; vs = 1; cyc(); lc = 0; vs = 0; cyc();
    check("co_state", int'(d_state), P_FLIGHT);
    check("co_nosave", n_save, 1);
    cyc();
    ball(900, 100); tick();
    rst = 1; cyc(); rst = 0; cyc();

    // Versus early finish after round 3.
    start(0);
    for (int i = 0; i < 3; i++) begin
      shot(600, 100);
      shot(100, 100);
    end
    check("early_state", int'(d_state), P_OVER);
    check("early_winner", int'(d_winner), 1);
    check("early_round", int'(d_round), 3);
    click();

    // Versus 5-5 tie.
    start(0);
    repeat (2 * ROUNDS) shot(600, 100);
`ifdef SUDDEN_DEATH_EN
    check("sd_state", int'(d_state), P_AIM);
    check("sd_round", int'(d_round), 6);
    shot(600, 100);
    shot(100, 100);
    check("sd_winner", int'(d_winner), 1);
    check("sd_over", int'(d_state), P_OVER);
`else
    check("tie_state", int'(d_state), P_OVER);
    check("tie_winner", int'(d_winner), 3);
    check("tie_round", int'(d_round), 5);
`endif
    click();

    // Reset during FLIGHT discards the match.
    start(1);
    repeat (2) shot(600, 100);
    click();
    check("pre_rst_state", int'(d_state), P_FLIGHT);
    check("pre_rst_sa", int'(d_sa), 2);
    rst = 1; cyc();
    check("rst_mid_state", int'(d_state), P_IDLE);
    check("rst_mid_sa", int'(d_sa), 0);
    rst = 0; cyc();
    ball(600, 100);
    check("post_rst_goal", last_goal, 0);
    check("post_rst_save", last_save, 0);

    // Randomized input stream.
    for (int c = 0; c < 15000; c++) begin
      if ($urandom_range(0, 5) == 0) lc = ~lc;
      vs = ($urandom_range(0, 4) == 0);
      bv = ($urandom_range(0, 7) == 0);
      solo_in = $urandom_range(0, 1) == 1;
      g = $urandom_range(0, 1000);
      x = g + $urandom_range(0, 260) - 130;
      if (x < 0) x = 0;
      gx = g[11:0];
      bx = x[11:0];
      rst = ($urandom_range(0, 2999) == 0);
      cyc();
    end
    rst = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/penalty_match_ctl.md
# penalty_match_ctl

Parametrised match controller for the penalty game. It supersedes the single-click solo/menu state selection with a full shootout sequencer:
- solo or two-player versus mode
- N-round regulation with per-shot aim timeout
- score counting and early termination

It sits between the mouse/gloves path and the screen selector. Its registered state, score and result outputs drive screen choice and overlay text.

## Interface
Parameters:
- ROUNDS, 5: regulation shots per player
- TIMEOUT_FRAMES, 180: frames allowed in AIM before the shot is forfeited
- SAVE_RADIUS, 64: pixel distance at or below which the keeper saves
- COORD_W, 12: coordinate width
- SCORE_W, 4: score counter width

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous, active-high reset
- solo_enable  in  1  1 = solo vs CPU keeper, 0 = versus; sampled only in IDLE
- left_clicked  in  1  mouse left button level
- vsync  in  1  VGA vsync level; rising edge = frame tick
- ball_valid  in  1  one-cycle pulse: ball reached goal line
- ball_x  in  COORD_W  ball x at goal line, valid with ball_valid
- glove_x  in  COORD_W  keeper glove centre x, sampled with ball_valid
- state  out  3  IDLE=0, AIM=1, FLIGHT=2, RESULT=3, OVER=4
- shooter  out  1  current shooter (0 = A, 1 = B); always 0 in solo
- round  out  8  current round, 1-based, saturates at 255
- score_a  out  SCORE_W  goals by A
- score_b  out  SCORE_W  goals by B (versus) / saves by CPU (solo)
- goal_pulse  out  1  one cycle per goal
- save_pulse  out  1  one cycle per save or forfeit
- winner  out  2  valid in OVER: 01 = A, 10 = B, 11 = draw

## Operation
- Click edge: left_clicked registered; click = rising edge. Frame tick = vsync rising edge, one-cycle internal strobe.
- IDLE: click latches mode, clears scores and aim timer, sets round=1 and shooter=0, then goes to AIM.
- AIM: the frame counter increments on each frame tick.
  - Click: go to FLIGHT.
  - Counter reaches TIMEOUT_FRAMES: forfeit, save_pulse, go to RESULT.
- FLIGHT: wait for ball_valid (ball_valid in any other state is ignored). Then compute |ball_x − glove_x| as COORD_W+1 signed.
  - distance ≤ SAVE_RADIUS: save, save_pulse.
  - Otherwise: goal, goal_pulse, shooter's score +1.
  - Go to RESULT.
- RESULT: hold for exactly one frame tick, then advance.
- Solo advance:
  - Save increments score_b.
  - round increments after every shot.
  - After shot ROUNDS, go to OVER. Winner A if score_a > score_b, B if less, draw if equal.
- Versus advance: shooter toggles after every shot; round increments after B shoots.
- Early termination (regulation only): remaining_x = shots player x has left, ROUNDS included. Go to OVER as soon as score_a > score_b + remaining_b, or score_b > score_a + remaining_a.
- End of regulation (versus): after round ROUNDS completes, unequal scores go to OVER with the leader as winner.
- OVER: holds all outputs; a click returns to IDLE.
- Scores saturate at 2^SCORE_W − 1.

## Timing
- All outputs registered. Reset values: state=IDLE, shooter=0, round=0, scores=0, pulses=0, winner=00.
- Click rising edge at cycle n: state changes at n+2 (one sync register plus the FSM register).
- ball_valid at cycle n: goal_pulse/save_pulse and the score update are visible at n+1, and state=RESULT at n+1.
- A click in the same cycle as timeout expiry is taken as a shot: FLIGHT wins and there is no forfeit.
- A second click while in FLIGHT or RESULT is ignored.
- Reset asserted mid-match returns immediately to the reset values. No partial score is retained.

## Configuration
- SUDDEN_DEATH_EN defined: a versus tie after regulation continues with extra rounds. After each completed round (B has shot), unequal scores go to OVER with the leader as winner. There is no early termination in sudden death.
- SUDDEN_DEATH_EN undefined: a versus tie after regulation goes to OVER with winner=11.
- Solo mode is unaffected by the macro.

## Test plan
- Solo, all goals: ROUNDS=5, ball_x=600, glove_x=100 each shot -> score_a=5, score_b=0, state=OVER, winner=01, five goal_pulses.
- Save boundary: ball_x=164, glove_x=100 (distance 64) -> save_pulse. Ball_x=165 -> goal_pulse.
- Timeout: no click in AIM for 180 frame ticks -> save_pulse on the 180th tick, score_b+1 (solo). A click coincident with that tick -> FLIGHT, no save_pulse.
- Versus early end: A scores 3, B saves 3 (after round 3) -> OVER right after B's 3rd shot (3 > 0+2), winner=01, round=3.
- Versus tie 5–5: with SUDDEN_DEATH_EN -> round 6 runs; A goal, B save -> winner=01. Without the macro -> OVER, winner=11 after round 5.
- Reset mid-FLIGHT with score_a=2 -> next cycle state=IDLE, all scores 0. A following ball_valid pulse produces no pulse output.
